mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
// Memory stage of the 16-bit 5-stage pipeline, directly downstream of EX.
// - Registers EX outputs (ALU dst, store data sdata, control).
// - Issues loads/stores to data memory over a req/ack handshake and stalls upstream while an access is pending.
// - Presents registered results to WB.
// - alu_result_MEM_WB is the EX forwarding source for forward code 2'b10.
// PARAMETERS
// DW       16  data/address width
// TIMEOUT  15  max ACCESS cycles without dmem_ack before abort; 0 = never abort
// PORTS
// clk                in   1   clock; single clock domain
// rst_n              in   1   reset, asynchronous, active-low
// valid_EX           in   1   EX holds a valid instruction
// dst_EX             in   DW  ALU result / effective address
// sdata_EX           in   DW  store data (post-forwarding)
// rd_en_EX           in   1   load
// wr_en_EX           in   1   store
// wb_en_EX           in   1   instruction writes a register
// wb_reg_EX          in   4   destination register
// hlt_EX             in   1   halt instruction
// stall_MEM          out  1   freeze PC/IF/ID/EX registers
// dmem_req           out  1   memory request
// dmem_we            out  1   1 = write
// dmem_addr          out  DW  address
// dmem_wdata         out  DW  write data
// dmem_ack           in   1   access complete; dmem_rdata valid same cycle
// dmem_rdata         in   DW  read data
// alu_result_MEM_WB  out  DW  registered ALU result
// mem_data_MEM_WB    out  DW  registered load data
// mem_to_reg_MEM_WB  out  1   WB selects load data
// wb_en_MEM_WB       out  1   register write enable
// wb_reg_MEM_WB      out  4   destination register
// hlt_MEM_WB         out  1   halt retired
// err                out  1   sticky access-timeout flag
// BEHAVIOUR
// - Reset (rst_n low, async): all outputs 0, FSM IDLE, EX/MEM register invalid, counter 0.
//   Reset mid-ACCESS drops dmem_req immediately; the instruction does not retire.
// - EX/MEM register:
//   - Loads EX inputs on each edge where stall_MEM=0; holds otherwise.
//   - valid_EX=0 loads a bubble (all enables 0).
//   - rd_en and wr_en both set: treated as a store, load ignored.
// - FSM {IDLE, ACCESS}:
//   - IDLE, non-memory instr: no stall; retires next edge (1-cycle latency).
//   - IDLE, memory instr: stall_MEM=1, next state ACCESS.
//   - ACCESS: dmem_req=1 with addr/we/wdata stable from the EX/MEM register.
//     - stall_MEM = !dmem_ack.
//     - On ack: capture rdata, retire, go to IDLE.
// - Minimum memory-op latency: 2 cycles in MEM (ack in first ACCESS cycle).
// - dmem_ack while in IDLE is ignored.
// - WB registers update only when stall_MEM=0.
//   - While stalled, wb_en/hlt/mem_to_reg outputs are 0 (bubble); data outputs hold.
//   - Stores retire with wb_en=0.
// - Timeout:
//   - Counter counts ACCESS cycles. When count reaches TIMEOUT with no ack: err<=1 (sticky until reset), drop req, go to IDLE.
//   - The instruction then retires with wb_en forced 0.
// - Halt: hlt retires as hlt_MEM_WB=1, which then holds. Later valid_EX is ignored (bubbles) until reset.
// CONFIGURATION
// MEM_STAGE_LAST_STORE_BYPASS_EN defined:
// - last_addr/last_data/last_vld track the most recent completed store; last_vld=0 on reset.
// - A load with last_vld && addr==last_addr completes from IDLE: no dmem_req, no stall, data=last_data.
// - A timed-out store does not update the tracker.
// Undefined: every load accesses memory.
// STRUCTURE
// - Package pipe_pkg: DW, REG_W=4, typedef enum mem_state_t {IDLE, ACCESS}, TIMEOUT counter width ($clog2(TIMEOUT+1)).
// - Sub-module dmem_ctrl: FSM, timeout counter, handshake, bypass tracker.
// - Top level: EX/MEM and MEM/WB registers.
// TESTING
// 1. ALU op: dst_EX=16'h1234, wb_en=1, reg 3 -> next edge alu_result_MEM_WB=1234, wb_en=1, wb_reg=3, stall_MEM never 1.
// 2. Load addr 16'h0040, ack on 3rd req cycle, rdata 16'hBEEF -> stall 3 cycles, req 3 cycles, mem_data=BEEF, mem_to_reg=1.
// 3. Store 16'hA5A5 to 16'h0010, ack in 1st cycle -> dmem_we=1, wdata=A5A5, 1 stall cycle, wb_en_MEM_WB=0.
// 4. TIMEOUT=15, no ack -> req high 15 cycles, err=1, instr retires wb_en=0, next ALU op proceeds normally.
// 5. rst_n low during ACCESS -> req 0 same cycle, all outputs 0, err 0; no retirement after release.
// 6. Bypass macro on: store 16'h1111 to 16'h0020, then load 16'h0020 -> no req, no stall, mem_data=1111.
//    Then halt -> hlt_MEM_WB=1 and held.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths, FSM state type and counter sizing for the MEM stage
//
// Purpose : common definitions imported by mem_stage and dmem_ctrl.
// Contents: DW (data/address width), REG_W (register index width),
//           TIMEOUT_DEF (default access timeout, 0 = never abort),
//           mem_state_t {IDLE, ACCESS}, cnt_width() and CNT_W for the
//           timeout counter.
package pipe_pkg;

    localparam int DW          = 16;
    localparam int REG_W       = 4;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    // A zero timeout still needs a 1-bit counter so the declaration stays legal.
    function automatic int cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

    localparam int CNT_W = cnt_width(TIMEOUT_DEF);

endpackage

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - data-memory access FSM, timeout counter and last-store bypass
//
// Purpose : runs one load/store from the EX/MEM register over the
//           dmem req/ack handshake and tells the top level when to stall.
// Macro   : MEM_STAGE_LAST_STORE_BYPASS_EN enables the last-store tracker
//           that lets a load to the last stored address finish from IDLE.
// Ports   : clk, rst_n       clock, async active-low reset
//           i_mem_vld        EX/MEM holds a valid load or store
//           i_is_store       that instruction is a store
//           i_addr/i_wdata   address and store data from EX/MEM
//           o_stall          freeze upstream and hold EX/MEM
//           o_ack            memory completed the access this cycle
//           o_timeout        access aborted this cycle
//           o_bypass         load served from the last-store tracker
//           o_rdata          load data (memory or tracker)
//           o_err            sticky timeout flag
//           dmem_*           memory handshake
module dmem_ctrl
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_mem_vld,
    input  logic          i_is_store,
    input  logic [DW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic          o_stall,
    output logic          o_ack,
    output logic          o_timeout,
    output logic          o_bypass,
    output logic [DW-1:0] o_rdata,
    output logic          o_err,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic          dmem_ack,
    input  logic [DW-1:0] dmem_rdata
);

    localparam int CW = cnt_width(TIMEOUT);

    mem_state_t    r_state;
    logic          r_req;
    logic          r_err;
    logic [CW-1:0] r_cnt;

    logic w_ack;
    logic w_timeout;
    logic w_bypass;

    // An ack outside ACCESS has no request to belong to, so it is dropped.
    assign w_ack = r_req & dmem_ack;

    // r_cnt holds the number of ACCESS cycles already spent without ack;
    // the abort lands on the TIMEOUT-th request cycle so req is high exactly
    // TIMEOUT cycles.
    generate
        if (TIMEOUT > 0) begin : g_timeout
            assign w_timeout = r_req & ~dmem_ack & (r_cnt == CW'(TIMEOUT - 1));
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

`ifdef MEM_STAGE_LAST_STORE_BYPASS_EN
    logic          r_last_vld;
    logic [DW-1:0] r_last_addr;
    logic [DW-1:0] r_last_data;

    assign w_bypass = (r_state == IDLE) & i_mem_vld & ~i_is_store &
                      r_last_vld & (i_addr == r_last_addr);
    assign o_rdata  = w_bypass ? r_last_data : dmem_rdata;

    // Only acknowledged stores are tracked; an aborted store never reached memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_vld  <= 1'b0;
            r_last_addr <= '0;
            r_last_data <= '0;
        end else if (w_ack && i_is_store) begin
            r_last_vld  <= 1'b1;
            r_last_addr <= i_addr;
            r_last_data <= i_wdata;
        end
    end
`else
    assign w_bypass = 1'b0;
    assign o_rdata  = dmem_rdata;
`endif

    // IDLE stalls for the cycle that launches the request; ACCESS releases
    // the stall on ack or on abort so the instruction retires that edge.
    assign o_stall   = (r_state == IDLE) ? (i_mem_vld & ~w_bypass)
                                         : (~dmem_ack & ~w_timeout);
    assign o_ack     = w_ack;
    assign o_timeout = w_timeout;
    assign o_bypass  = w_bypass;
    assign o_err     = r_err;

    assign dmem_req   = r_req;
    assign dmem_we    = r_req & i_is_store;
    assign dmem_addr  = r_req ? i_addr : '0;
    assign dmem_wdata = (r_req & i_is_store) ? i_wdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_mem_vld && !w_bypass) begin
                        r_state <= ACCESS;
                        r_req   <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                ACCESS: begin
                    if (dmem_ack) begin
                        r_state <= IDLE;
                        r_req   <= 1'b0;
                    end else if (w_timeout) begin
                        r_state <= IDLE;
                        r_req   <= 1'b0;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM stage of the 16-bit 5-stage pipeline (EX/MEM and MEM/WB registers)
//
// Purpose : registers EX results, runs loads/stores through dmem_ctrl,
//           stalls upstream while an access is pending and presents the
//           registered results to WB. alu_result_MEM_WB also feeds EX
//           forwarding (code 2'b10).
// Macro   : MEM_STAGE_LAST_STORE_BYPASS_EN (see dmem_ctrl) lets a load that
//           hits the most recent completed store finish without memory.
// Ports   : clk, rst_n                      clock, async active-low reset
//           valid_EX .. hlt_EX              instruction from EX
//           stall_MEM                       freeze PC/IF/ID/EX
//           dmem_req/we/addr/wdata/ack/rdata data-memory handshake
//           *_MEM_WB                        registered results to WB
//           err                             sticky access-timeout flag
module mem_stage
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_EX,
    input  logic [DW-1:0]    dst_EX,
    input  logic [DW-1:0]    sdata_EX,
    input  logic             rd_en_EX,
    input  logic             wr_en_EX,
    input  logic             wb_en_EX,
    input  logic [REG_W-1:0] wb_reg_EX,
    input  logic             hlt_EX,
    output logic             stall_MEM,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [DW-1:0]    dmem_addr,
    output logic [DW-1:0]    dmem_wdata,
    input  logic             dmem_ack,
    input  logic [DW-1:0]    dmem_rdata,
    output logic [DW-1:0]    alu_result_MEM_WB,
    output logic [DW-1:0]    mem_data_MEM_WB,
    output logic             mem_to_reg_MEM_WB,
    output logic             wb_en_MEM_WB,
    output logic [REG_W-1:0] wb_reg_MEM_WB,
    output logic             hlt_MEM_WB,
    output logic             err
);

    // EX/MEM register; every enable already carries the valid qualifier.
    logic             r_vld;
    logic [DW-1:0]    r_dst;
    logic [DW-1:0]    r_sdata;
    logic             r_rd;
    logic             r_wr;
    logic             r_wb_en;
    logic [REG_W-1:0] r_wb_reg;
    logic             r_hlt;
    logic             r_halted;

    // MEM/WB register
    logic [DW-1:0]    r_alu_wb;
    logic [DW-1:0]    r_mem_wb;
    logic             r_m2r_wb;
    logic             r_wben_wb;
    logic [REG_W-1:0] r_reg_wb;
    logic             r_hlt_wb;

    logic          w_stall;
    logic          w_take;
    logic          w_mem_vld;
    logic          w_ack;
    logic          w_timeout;
    logic          w_bypass;
    logic [DW-1:0] w_rdata;

    // Once a halt has entered the stage nothing behind it may execute.
    assign w_take    = valid_EX & ~r_halted;
    assign w_mem_vld = r_vld & (r_rd | r_wr);

    dmem_ctrl #(
        .TIMEOUT (TIMEOUT)
    ) u_dmem_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_mem_vld  (w_mem_vld),
        .i_is_store (r_wr),
        .i_addr     (r_dst),
        .i_wdata    (r_sdata),
        .o_stall    (w_stall),
        .o_ack      (w_ack),
        .o_timeout  (w_timeout),
        .o_bypass   (w_bypass),
        .o_rdata    (w_rdata),
        .o_err      (err),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld    <= 1'b0;
            r_dst    <= '0;
            r_sdata  <= '0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_wb_en  <= 1'b0;
            r_wb_reg <= '0;
            r_hlt    <= 1'b0;
            r_halted <= 1'b0;
        end else if (!w_stall) begin
            r_vld    <= w_take;
            r_dst    <= dst_EX;
            r_sdata  <= sdata_EX;
            // A combined read/write is a store; the read half is discarded.
            r_wr     <= w_take & wr_en_EX;
            r_rd     <= w_take & rd_en_EX & ~wr_en_EX;
            // Stores never write a register.
            r_wb_en  <= w_take & wb_en_EX & ~wr_en_EX;
            r_wb_reg <= wb_reg_EX;
            r_hlt    <= w_take & hlt_EX;
            if (w_take && hlt_EX) begin
                r_halted <= 1'b1;
            end
        end
    end

    // Stall edges push a bubble to WB but keep the data fields, so
    // forwarding from alu_result_MEM_WB stays stable across the stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_wb  <= '0;
            r_mem_wb  <= '0;
            r_m2r_wb  <= 1'b0;
            r_wben_wb <= 1'b0;
            r_reg_wb  <= '0;
            r_hlt_wb  <= 1'b0;
        end else if (w_stall) begin
            r_m2r_wb  <= 1'b0;
            r_wben_wb <= 1'b0;
        end else begin
            r_m2r_wb  <= r_rd;
            r_wben_wb <= r_wb_en & ~w_timeout;
            r_hlt_wb  <= r_hlt_wb | r_hlt;
            if (r_vld) begin
                r_alu_wb <= r_dst;
                r_reg_wb <= r_wb_reg;
            end
            if ((w_ack && r_rd) || w_bypass) begin
                r_mem_wb <= w_rdata;
            end
        end
    end

    assign stall_MEM         = w_stall;
    assign alu_result_MEM_WB = r_alu_wb;
    assign mem_data_MEM_WB   = r_mem_wb;
    assign mem_to_reg_MEM_WB = r_m2r_wb;
    assign wb_en_MEM_WB      = r_wben_wb;
    assign wb_reg_MEM_WB     = r_reg_wb;
    assign hlt_MEM_WB        = r_hlt_wb;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage with a behavioural memory model
module tb_mem_stage;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_EX = 1'b0;
    logic [15:0] dst_EX = '0;
    logic [15:0] sdata_EX = '0;
    logic        rd_en_EX = 1'b0;
    logic        wr_en_EX = 1'b0;
    logic        wb_en_EX = 1'b0;
    logic [3:0]  wb_reg_EX = '0;
    logic        hlt_EX = 1'b0;
    logic        stall_MEM;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic        dmem_ack = 1'b0;
    logic [15:0] dmem_rdata = '0;
    logic [15:0] alu_result_MEM_WB;
    logic [15:0] mem_data_MEM_WB;
    logic        mem_to_reg_MEM_WB;
    logic        wb_en_MEM_WB;
    logic [3:0]  wb_reg_MEM_WB;
    logic        hlt_MEM_WB;
    logic        err;

    mem_stage dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .valid_EX          (valid_EX),
        .dst_EX            (dst_EX),
        .sdata_EX          (sdata_EX),
        .rd_en_EX          (rd_en_EX),
        .wr_en_EX          (wr_en_EX),
        .wb_en_EX          (wb_en_EX),
        .wb_reg_EX         (wb_reg_EX),
        .hlt_EX            (hlt_EX),
        .stall_MEM         (stall_MEM),
        .dmem_req          (dmem_req),
        .dmem_we           (dmem_we),
        .dmem_addr         (dmem_addr),
        .dmem_wdata        (dmem_wdata),
        .dmem_ack          (dmem_ack),
        .dmem_rdata        (dmem_rdata),
        .alu_result_MEM_WB (alu_result_MEM_WB),
        .mem_data_MEM_WB   (mem_data_MEM_WB),
        .mem_to_reg_MEM_WB (mem_to_reg_MEM_WB),
        .wb_en_MEM_WB      (wb_en_MEM_WB),
        .wb_reg_MEM_WB     (wb_reg_MEM_WB),
        .hlt_MEM_WB        (hlt_MEM_WB),
        .err               (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Memory contents as seen by the pipeline, and the last acknowledged store.
    logic [15:0] mem_model [logic [15:0]];
    logic        trk_vld = 1'b0;
    logic [15:0] trk_addr = '0;

    // Drives one instruction, plays the memory (ack on the ack_at-th request
    // cycle, never when 0) and returns what it observed up to retirement.
    task automatic run_instr(input logic v, input logic rd, input logic wr,
                             input logic wbe, input logic hlt, input logic [3:0] rg,
                             input logic [15:0] dst, input logic [15:0] sd,
                             input int ack_at, input logic [15:0] rdata,
                             output int stalls, output int reqs,
                             output int bus_bad, output int wb_bad, output logic hung);
        logic done;
        logic prev_stall;
        stalls = 0; reqs = 0; bus_bad = 0; wb_bad = 0;
        done = 1'b0; prev_stall = 1'b0;
        @(negedge clk);
        valid_EX = v; rd_en_EX = rd; wr_en_EX = wr; wb_en_EX = wbe;
        hlt_EX = hlt; wb_reg_EX = rg; dst_EX = dst; sdata_EX = sd;
        dmem_ack = 1'b0;
        @(posedge clk);
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            valid_EX = 1'b0; rd_en_EX = 1'b0; wr_en_EX = 1'b0;
            wb_en_EX = 1'b0; hlt_EX = 1'b0;
            dmem_ack = 1'b0;
            if (prev_stall && (wb_en_MEM_WB || mem_to_reg_MEM_WB)) wb_bad++;
            if (dmem_req) begin
                reqs++;
                if (dmem_addr !== dst || dmem_we !== wr || (wr && dmem_wdata !== sd)) bus_bad++;
                if (ack_at != 0 && reqs == ack_at) begin
                    dmem_ack = 1'b1;
                    dmem_rdata = rdata;
                    if (wr) begin
                        mem_model[dst] = sd;
                        trk_vld = 1'b1;
                        trk_addr = dst;
                    end
                end
            end
            #1;
            prev_stall = stall_MEM;
            if (stall_MEM) stalls++;
            else done = 1'b1;
        end
        hung = !done;
        @(negedge clk);
        dmem_ack = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        logic [87:0] obs;
        rst_n = 1'b0;
        trk_vld = 1'b0;
        repeat (3) @(negedge clk);
        obs = {stall_MEM, dmem_req, dmem_we, dmem_addr, dmem_wdata, alu_result_MEM_WB,
               mem_data_MEM_WB, mem_to_reg_MEM_WB, wb_en_MEM_WB, wb_reg_MEM_WB, hlt_MEM_WB, err};
        n_cmp++;
        if (obs !== '0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", obs); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        obs = {stall_MEM, dmem_req, dmem_we, dmem_addr, dmem_wdata, alu_result_MEM_WB,
               mem_data_MEM_WB, mem_to_reg_MEM_WB, wb_en_MEM_WB, wb_reg_MEM_WB, hlt_MEM_WB, err};
        n_cmp++;
        if (obs !== '0) begin n_bad++; $display("FAIL reset_idle: got %h want 0", obs); end
    endtask

    task automatic test_alu;
        int s, r, bb, wb; logic h;
        run_instr(1, 0, 0, 1, 0, 4'd3, 16'h1234, 16'h0, 0, 16'h0, s, r, bb, wb, h);
        n_cmp++;
        if (h || s != 0 || r != 0) begin n_bad++; $display("FAIL alu_flow: hung %0d stalls %0d reqs %0d want 0 0 0", h, s, r); end
        n_cmp++;
        if ({alu_result_MEM_WB, wb_en_MEM_WB, wb_reg_MEM_WB, mem_to_reg_MEM_WB} !== {16'h1234, 1'b1, 4'd3, 1'b0}) begin
            n_bad++; $display("FAIL alu_result: got %h en %b reg %0d m2r %b want 1234 1 3 0",
                              alu_result_MEM_WB, wb_en_MEM_WB, wb_reg_MEM_WB, mem_to_reg_MEM_WB);
        end
    endtask

    task automatic test_load;
        int s, r, bb, wb; logic h;
        run_instr(1, 1, 0, 1, 0, 4'd5, 16'h0040, 16'h0, 3, 16'hBEEF, s, r, bb, wb, h);
        mem_model[16'h0040] = 16'hBEEF;
        n_cmp++;
        if (h || s != 3 || r != 3) begin n_bad++; $display("FAIL load_flow: hung %0d stalls %0d reqs %0d want 0 3 3", h, s, r); end
        n_cmp++;
        if (bb != 0 || wb != 0) begin n_bad++; $display("FAIL load_bus: bus_bad %0d stall_wb_bad %0d want 0 0", bb, wb); end
        n_cmp++;
        if ({mem_data_MEM_WB, mem_to_reg_MEM_WB, wb_en_MEM_WB, wb_reg_MEM_WB} !== {16'hBEEF, 1'b1, 1'b1, 4'd5}) begin
            n_bad++; $display("FAIL load_result: got %h m2r %b en %b reg %0d want BEEF 1 1 5",
                              mem_data_MEM_WB, mem_to_reg_MEM_WB, wb_en_MEM_WB, wb_reg_MEM_WB);
        end
    endtask

    task automatic test_store;
        int s, r, bb, wb; logic h;
        run_instr(1, 0, 1, 1, 0, 4'd6, 16'h0010, 16'hA5A5, 1, 16'h0, s, r, bb, wb, h);
        n_cmp++;
        if (h || s != 1 || r != 1 || bb != 0) begin
            n_bad++; $display("FAIL store_flow: hung %0d stalls %0d reqs %0d bus_bad %0d want 0 1 1 0", h, s, r, bb);
        end
        n_cmp++;
        if (wb_en_MEM_WB !== 1'b0 || mem_to_reg_MEM_WB !== 1'b0) begin
            n_bad++; $display("FAIL store_retire: wb_en %b m2r %b want 0 0", wb_en_MEM_WB, mem_to_reg_MEM_WB);
        end
    endtask

    task automatic test_bypass;
        int s, r, bb, wb, exp_r; logic h;
        run_instr(1, 0, 1, 0, 0, 4'd0, 16'h0020, 16'h1111, 1, 16'h0, s, r, bb, wb, h);
`ifdef MEM_STAGE_LAST_STORE_BYPASS_EN
        exp_r = 0;
`else
        exp_r = 2;
`endif
        run_instr(1, 1, 0, 1, 0, 4'd7, 16'h0020, 16'h0, 2, mem_model[16'h0020], s, r, bb, wb, h);
        n_cmp++;
        if (h || s != exp_r || r != exp_r) begin
            n_bad++; $display("FAIL bypass_flow: hung %0d stalls %0d reqs %0d want 0 %0d %0d", h, s, r, exp_r, exp_r);
        end
        n_cmp++;
        if (mem_data_MEM_WB !== 16'h1111 || wb_en_MEM_WB !== 1'b1) begin
            n_bad++; $display("FAIL bypass_data: got %h en %b want 1111 1", mem_data_MEM_WB, wb_en_MEM_WB);
        end
    endtask

    task automatic test_random;
        logic [15:0] addrs [4];
        int kind, lat, s, r, bb, wb, exp_r;
        logic h, v, rd, wr, wbe, hit, is_load, exp_wbe;
        logic [3:0]  rg;
        logic [15:0] dst, sd, exp_data;
        addrs[0] = 16'h0010; addrs[1] = 16'h0020; addrs[2] = 16'h0040; addrs[3] = 16'h0080;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 4);
            lat  = $urandom_range(1, 4);
            rg   = 4'($urandom);
            sd   = 16'($urandom);
            wbe  = 1'($urandom);
            v    = (kind != 4);
            rd   = (kind == 1) || (kind == 3) || (kind == 4 && $urandom_range(0, 1) == 1);
            wr   = (kind == 2) || (kind == 3) || (kind == 4 && $urandom_range(0, 1) == 1);
            dst  = (kind == 0) ? 16'($urandom) : addrs[$urandom_range(0, 3)];
            is_load = v && rd && !wr;
            if (is_load && !mem_model.exists(dst)) mem_model[dst] = 16'($urandom);
            exp_data = is_load ? mem_model[dst] : 16'h0;
`ifdef MEM_STAGE_LAST_STORE_BYPASS_EN
            hit = is_load && trk_vld && (trk_addr == dst);
`else
            hit = 1'b0;
`endif
            exp_r   = (v && (rd || wr) && !hit) ? lat : 0;
            exp_wbe = v && wbe && !wr;
            run_instr(v, rd, wr, wbe, 0, rg, dst, sd, lat, exp_data, s, r, bb, wb, h);
            n_cmp++;
            if (h || s != exp_r || r != exp_r || bb != 0 || wb != 0) begin
                n_bad++; $display("FAIL rand[%0d] flow kind %0d: hung %0d stalls %0d reqs %0d bus %0d wb %0d want stalls=reqs=%0d",
                                  i, kind, h, s, r, bb, wb, exp_r);
            end
            n_cmp++;
            if (wb_en_MEM_WB !== exp_wbe || mem_to_reg_MEM_WB !== is_load || hlt_MEM_WB !== 1'b0 || err !== 1'b0) begin
                n_bad++; $display("FAIL rand[%0d] ctrl: en %b m2r %b hlt %b err %b want %b %b 0 0",
                                  i, wb_en_MEM_WB, mem_to_reg_MEM_WB, hlt_MEM_WB, err, exp_wbe, is_load);
            end
            if (exp_wbe) begin
                n_cmp++;
                if (wb_reg_MEM_WB !== rg) begin n_bad++; $display("FAIL rand[%0d] wb_reg: got %0d want %0d", i, wb_reg_MEM_WB, rg); end
            end
            if (v) begin
                n_cmp++;
                if (alu_result_MEM_WB !== dst) begin n_bad++; $display("FAIL rand[%0d] alu: got %h want %h", i, alu_result_MEM_WB, dst); end
            end
            if (is_load) begin
                n_cmp++;
                if (mem_data_MEM_WB !== exp_data) begin n_bad++; $display("FAIL rand[%0d] load_data: got %h want %h", i, mem_data_MEM_WB, exp_data); end
            end
        end
    endtask

    task automatic test_timeout;
        int s, r, bb, wb; logic h;
        run_instr(1, 1, 0, 1, 0, 4'd9, 16'h0030, 16'h0, 0, 16'h0, s, r, bb, wb, h);
        n_cmp++;
        if (h || r != TO || bb != 0) begin n_bad++; $display("FAIL timeout_req: hung %0d reqs %0d bus %0d want 0 %0d 0", h, r, bb, TO); end
        n_cmp++;
        if (err !== 1'b1 || wb_en_MEM_WB !== 1'b0) begin n_bad++; $display("FAIL timeout_retire: err %b wb_en %b want 1 0", err, wb_en_MEM_WB); end
        run_instr(1, 0, 0, 1, 0, 4'd2, 16'h5A5A, 16'h0, 0, 16'h0, s, r, bb, wb, h);
        n_cmp++;
        if (h || s != 0 || r != 0 || alu_result_MEM_WB !== 16'h5A5A || wb_en_MEM_WB !== 1'b1 || err !== 1'b1) begin
            n_bad++; $display("FAIL timeout_next_alu: stalls %0d reqs %0d alu %h en %b err %b want 0 0 5a5a 1 1",
                              s, r, alu_result_MEM_WB, wb_en_MEM_WB, err);
        end
    endtask

    task automatic test_reset_mid_access;
        logic [87:0] obs;
        int bad;
        @(negedge clk);
        valid_EX = 1'b1; rd_en_EX = 1'b1; wr_en_EX = 1'b0; wb_en_EX = 1'b1;
        wb_reg_EX = 4'd4; dst_EX = 16'h0044;
        @(posedge clk);
        @(negedge clk);
        valid_EX = 1'b0; rd_en_EX = 1'b0; wb_en_EX = 1'b0;
        for (int c = 0; c < 10 && !dmem_req; c++) @(negedge clk);
        n_cmp++;
        if (dmem_req !== 1'b1) begin n_bad++; $display("FAIL rstmid_req_start: got %b want 1", dmem_req); end
        @(negedge clk);
        rst_n = 1'b0;
        trk_vld = 1'b0;
        #1;
        obs = {stall_MEM, dmem_req, dmem_we, dmem_addr, dmem_wdata, alu_result_MEM_WB,
               mem_data_MEM_WB, mem_to_reg_MEM_WB, wb_en_MEM_WB, wb_reg_MEM_WB, hlt_MEM_WB, err};
        n_cmp++;
        if (obs !== '0) begin n_bad++; $display("FAIL rstmid_outputs: got %h want 0", obs); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dmem_ack = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (wb_en_MEM_WB || mem_to_reg_MEM_WB || dmem_req || stall_MEM || err) bad++;
        end
        dmem_ack = 1'b0;
        n_cmp++;
        if (bad != 0) begin n_bad++; $display("FAIL rstmid_no_retire: active cycles %0d want 0", bad); end
    endtask

    task automatic test_halt;
        int s, r, bb, wb; logic h;
        run_instr(1, 0, 0, 0, 1, 4'd0, 16'h0, 16'h0, 0, 16'h0, s, r, bb, wb, h);
        n_cmp++;
        if (h || hlt_MEM_WB !== 1'b1) begin n_bad++; $display("FAIL halt_retire: hung %0d hlt %b want 0 1", h, hlt_MEM_WB); end
        run_instr(1, 1, 0, 1, 0, 4'd8, 16'h0040, 16'h0, 1, 16'h0, s, r, bb, wb, h);
        n_cmp++;
        if (h || r != 0 || s != 0 || wb_en_MEM_WB !== 1'b0 || hlt_MEM_WB !== 1'b1) begin
            n_bad++; $display("FAIL halt_ignore_load: reqs %0d stalls %0d en %b hlt %b want 0 0 0 1", r, s, wb_en_MEM_WB, hlt_MEM_WB);
        end
        run_instr(1, 0, 0, 1, 0, 4'd1, 16'h7777, 16'h0, 0, 16'h0, s, r, bb, wb, h);
        n_cmp++;
        if (wb_en_MEM_WB !== 1'b0 || hlt_MEM_WB !== 1'b1) begin
            n_bad++; $display("FAIL halt_ignore_alu: en %b hlt %b want 0 1", wb_en_MEM_WB, hlt_MEM_WB);
        end
        test_reset();
        run_instr(1, 0, 0, 1, 0, 4'd1, 16'h7777, 16'h0, 0, 16'h0, s, r, bb, wb, h);
        n_cmp++;
        if (wb_en_MEM_WB !== 1'b1 || hlt_MEM_WB !== 1'b0 || alu_result_MEM_WB !== 16'h7777) begin
            n_bad++; $display("FAIL halt_cleared: en %b hlt %b alu %h want 1 0 7777", wb_en_MEM_WB, hlt_MEM_WB, alu_result_MEM_WB);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_bypass();
        test_random();
        test_timeout();
        test_reset_mid_access();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
